// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: shared types and field positions for the MIPS core front end.
// Rev 1.0
package mips_pkg;

  localparam int INSTR_W   = 32;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// fetch_pc: program counter with redirect load, +4 increment and word alignment.
// Rev 1.0
module fetch_pc
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] target_i,
  input  logic               inc_i,
  output logic [INSTR_W-1:0] pc_o
);

  localparam logic [INSTR_W-1:0] ALIGN_MASK = ~32'h0000_0003;

  logic [INSTR_W-1:0] pc_d;
  logic [INSTR_W-1:0] pc_q;

  // A redirect overrides the increment: the fetched word is on the wrong path.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ALIGN_MASK;
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: single-outstanding instruction fetch with redirect kill and decode handshake.
// Rev 1.0
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               pc_load,
  input  logic [INSTR_W-1:0] pc_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [INSTR_W-1:0] id_pc,
  output logic [INSTR_W-1:0] id_pc_plus4,
  output logic [5:0]         id_op,
  output logic [5:0]         id_funct
);

  fetch_state_t       state_q, state_d;
  logic               kill_q, kill_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] id_pc_q;
  logic [INSTR_W-1:0] pc;
  logic               capture;
  logic               pc_inc;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_i   (pc_load),
    .target_i (pc_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    capture = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A redirect in the acceptance cycle is too late to change the address.
        if (imem_ready) begin
          state_d = ST_WAIT;
          kill_d  = pc_load;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || pc_load) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = ST_HOLD;
            capture = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (pc_load) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (pc_load || id_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == ST_REQ);
    id_valid = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= '0;
      id_pc_q <= '0;
    end else if (capture) begin
      ir_q    <= imem_rdata;
      id_pc_q <= pc;
    end
  end

  assign imem_addr   = pc;
  assign id_instr    = ir_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign id_op       = ir_q[OP_MSB:OP_LSB];
  assign id_funct    = ir_q[FUNCT_MSB:0];

endmodule
`default_nettype wire
